// File: rtl/led_chain_shifter.sv
// led_chain_shifter: serialises 769-bit latch frames (select + 768 data) onto NUM_LANES SDO lanes.
// Latency: one bit per 2*SCLK_HALF CLK cycles; a rd_data word is shown on SDO in the cycle it is valid.
// No backpressure on the frame store; frame_go gates only the grayscale LAT. Macro LANE_MASK_EN adds lane_mask.
module led_chain_shifter #(
  parameter int NUM_LANES   = 48,
  parameter int NUM_CHAINED = 2,
  parameter int SCLK_HALF   = 2,
  parameter int CHIP_W      = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [20:0]          cfg_dc,
  input  logic [8:0]           cfg_mc,
  input  logic [20:0]          cfg_bc,
  input  logic [4:0]           cfg_fc,
  input  logic                 cfg_reload,
`ifdef LANE_MASK_EN
  input  logic [NUM_LANES-1:0] lane_mask,
`endif
  input  logic                 frame_go,
  output logic                 rd_req,
  output logic [CHIP_W-1:0]    rd_chip,
  output logic [9:0]           rd_bit,
  input  logic [NUM_LANES-1:0] rd_data,
  output logic [NUM_LANES-1:0] SDO,
  output logic                 SCLK,
  output logic                 LAT,
  output logic                 busy,
  output logic                 wait_go,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_END_CHIP = 3'd4,
    S_WAIT_GO  = 3'd5,
    S_LATCH    = 3'd6,
    S_GAP      = 3'd7
  } state_t;

  // LOAD is the first low cycle, SHIFT_LO covers the remaining SCLK_HALF-1 low cycles.
  localparam int                PH_W       = $clog2(SCLK_HALF);
  localparam logic [PH_W-1:0]   PH_LO_END  = PH_W'(SCLK_HALF - 2);
  localparam logic [PH_W-1:0]   PH_HI_END  = PH_W'(SCLK_HALF - 1);
  localparam logic [9:0]        SEL_BIT    = 10'd768;
  localparam logic [CHIP_W-1:0] CHIP_FIRST = CHIP_W'(NUM_CHAINED - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PH_W-1:0]       r_ph;
  logic [CHIP_W-1:0]     r_chip;
  logic [9:0]            r_bit;
  logic                  r_ctrl;
  logic                  r_init;
  logic                  r_go_pend;
  logic                  r_reload_pend;
  logic [20:0]           r_dc;
  logic [8:0]            r_mc;
  logic [20:0]           r_bc;
  logic [4:0]            r_fc;
  logic [NUM_LANES-1:0]  r_sdo;
  logic                  r_rd_vld;
  logic                  r_sclk;
  logic                  r_lat;
  logic                  r_busy;
  logic                  r_wait_go;
  logic                  r_frame_done;

  logic                  w_start_ctrl;
  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_gray_shift;
  logic                  w_rd_req;
  logic                  w_bit_val;
  logic [767:0]          w_ctrl_data;
  logic [NUM_LANES-1:0]  w_lanes_on;

`ifdef LANE_MASK_EN
  logic [NUM_LANES-1:0]  r_mask;

  // Lane enable mask is frozen for the whole frame.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_mask <= '0;
    end else if (r_state == S_IDLE) begin
      r_mask <= lane_mask;
    end
  end

  assign w_lanes_on = r_mask;
`else
  assign w_lanes_on = {NUM_LANES{1'b1}};
`endif

  assign w_start_ctrl = r_init | r_reload_pend;
  assign w_bit_end    = (r_state == S_SHIFT_HI) && (r_ph == PH_HI_END);
  assign w_last_bit   = (r_bit == 10'd0) && (r_chip == '0);
  assign w_gray_shift = !r_ctrl && ((r_state == S_LOAD) || (r_state == S_SHIFT_LO) ||
                                    (r_state == S_SHIFT_HI) || (r_state == S_END_CHIP));

  // Frame-store reads only for grayscale data bits, in the first low cycle of the bit.
  assign w_rd_req = (r_state == S_LOAD) && !r_ctrl && (r_bit != SEL_BIT);
  assign rd_req   = w_rd_req;
  assign rd_chip  = w_rd_req ? r_chip : '0;
  assign rd_bit   = w_rd_req ? r_bit : 10'd0;

  // Control latch image assembled from the configuration sampled at frame start.
  always_comb begin
    w_ctrl_data = '0;
    for (int k = 0; k < 16; k++) begin
      w_ctrl_data[21*k +: 21] = r_dc;
    end
    w_ctrl_data[344:336] = r_mc;
    w_ctrl_data[365:345] = r_bc;
    w_ctrl_data[370:366] = r_fc;
    w_ctrl_data[767:760] = 8'h96;
  end

  // Value of the current bit when it does not come from the frame store.
  always_comb begin
    w_bit_val = 1'b0;
    if (r_bit == SEL_BIT) begin
      w_bit_val = r_ctrl;
    end else if (r_ctrl) begin
      w_bit_val = w_ctrl_data[r_bit];
    end
  end

  // Next-state sequencing of the frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     w_state_nxt = S_LOAD;
      S_LOAD:     w_state_nxt = S_SHIFT_LO;
      S_SHIFT_LO: if (r_ph == PH_LO_END) w_state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: if (r_ph == PH_HI_END) w_state_nxt = w_last_bit ? S_END_CHIP : S_LOAD;
      S_END_CHIP: w_state_nxt = r_ctrl ? S_LATCH : S_WAIT_GO;
      S_WAIT_GO:  if (r_go_pend || frame_go) w_state_nxt = S_LATCH;
      S_LATCH:    w_state_nxt = S_GAP;
      S_GAP:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SCLK phase counter inside the low and high halves of a bit.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ph <= '0;
    end else begin
      case (r_state)
        S_SHIFT_LO: r_ph <= (r_ph == PH_LO_END) ? '0 : r_ph + 1'b1;
        S_SHIFT_HI: r_ph <= (r_ph == PH_HI_END) ? '0 : r_ph + 1'b1;
        default:    r_ph <= '0;
      endcase
    end
  end

  // Chip / bit position: MSB first, highest chip first, select bit leads every chip.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_chip <= '0;
      r_bit  <= 10'd0;
    end else if (r_state == S_IDLE) begin
      r_chip <= CHIP_FIRST;
      r_bit  <= SEL_BIT;
    end else if (w_bit_end) begin
      if (r_bit != 10'd0) begin
        r_bit <= r_bit - 10'd1;
      end else if (r_chip != '0) begin
        r_chip <= r_chip - CHIP_W'(1);
        r_bit  <= SEL_BIT;
      end
    end
  end

  // Frame type selection and configuration snapshot at frame start.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ctrl <= 1'b0;
      r_init <= 1'b1;
      r_dc   <= '0;
      r_mc   <= '0;
      r_bc   <= '0;
      r_fc   <= '0;
    end else if (r_state == S_IDLE) begin
      r_ctrl <= w_start_ctrl;
      r_init <= 1'b0;
      r_dc   <= cfg_dc;
      r_mc   <= cfg_mc;
      r_bc   <= cfg_bc;
      r_fc   <= cfg_fc;
    end
  end

  // Sticky reload request; one arriving while a control frame starts is served by that frame.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_reload_pend <= 1'b0;
    end else if ((r_state == S_IDLE) && w_start_ctrl) begin
      r_reload_pend <= 1'b0;
    end else if (cfg_reload) begin
      r_reload_pend <= 1'b1;
    end
  end

  // Early go from the encoder, remembered only while a grayscale frame is shifting.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_go_pend <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_go_pend <= 1'b0;
    end else if ((r_state == S_WAIT_GO) && (w_state_nxt == S_LATCH)) begin
      r_go_pend <= 1'b0;
    end else if (w_gray_shift && frame_go) begin
      r_go_pend <= 1'b1;
    end
  end

  // SDO holding register: internal bits load at the end of LOAD, read data when it arrives.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_sdo    <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_req;
      if ((r_state == S_LOAD) && !w_rd_req) begin
        r_sdo <= w_lanes_on & {NUM_LANES{w_bit_val}};
      end else if (r_rd_vld) begin
        r_sdo <= w_lanes_on & rd_data;
      end
    end
  end

  // Read data is passed straight through in its valid cycle so SDO settles in the 2nd low
  // cycle even when SCLK_HALF is 2; the register holds it through the high phase.
  assign SDO = r_rd_vld ? (w_lanes_on & rd_data) : r_sdo;

  // Glitch-free registered strobes decoded from the next state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_sclk       <= 1'b0;
      r_lat        <= 1'b0;
      r_busy       <= 1'b0;
      r_wait_go    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sclk       <= (w_state_nxt == S_SHIFT_HI);
      r_lat        <= (w_state_nxt == S_LATCH);
      r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_WAIT_GO);
      r_wait_go    <= (w_state_nxt == S_WAIT_GO);
      r_frame_done <= (w_state_nxt == S_LATCH) && !r_ctrl;
    end
  end

  assign SCLK       = r_sclk;
  assign LAT        = r_lat;
  assign busy       = r_busy;
  assign wait_go    = r_wait_go;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_chain_shifter.sv
// tb_led_chain_shifter: random frame-store contents and configurations against a frame-level model.
// Expected SDO streams are built per frame from the latch-frame rules; reads are served one cycle late.
// Frame sequencing covers go before/after shift end, discarded go, reload, and reset mid-frame.
module tb_led_chain_shifter;

  localparam int NL = 48;
  localparam int NC = 2;
  localparam int SH = 2;
  localparam int CW = 1;
  localparam int NB = 769 * NC;

  logic           CLK;
  logic           Reset;
  logic [20:0]    cfg_dc;
  logic [8:0]     cfg_mc;
  logic [20:0]    cfg_bc;
  logic [4:0]     cfg_fc;
  logic           cfg_reload;
  logic           frame_go;
  logic           rd_req;
  logic [CW-1:0]  rd_chip;
  logic [9:0]     rd_bit;
  logic [NL-1:0]  rd_data;
  logic [NL-1:0]  SDO;
  logic           SCLK;
  logic           LAT;
  logic           busy;
  logic           wait_go;
  logic           frame_done;
  logic [NL-1:0]  tb_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fd_cnt  = 0;
  int lat_sclk_bad = 0;
  int bw_bad  = 0;
  int lat_cyc = 0;
  int rel_cyc = 0;
  logic prev_sclk = 1'b0;

  logic [NL-1:0]    q_sdo[$];
  logic [CW+9:0]    q_rd[$];
  logic             q_lat[$];
  logic [NL-1:0]    mem[NC][768];

  led_chain_shifter #(.NUM_LANES(NL), .NUM_CHAINED(NC), .SCLK_HALF(SH), .CHIP_W(CW)) dut (
    .CLK(CLK), .Reset(Reset),
    .cfg_dc(cfg_dc), .cfg_mc(cfg_mc), .cfg_bc(cfg_bc), .cfg_fc(cfg_fc),
    .cfg_reload(cfg_reload),
`ifdef LANE_MASK_EN
    .lane_mask(tb_mask),
`endif
    .frame_go(frame_go),
    .rd_req(rd_req), .rd_chip(rd_chip), .rd_bit(rd_bit), .rd_data(rd_data),
    .SDO(SDO), .SCLK(SCLK), .LAT(LAT), .busy(busy), .wait_go(wait_go),
    .frame_done(frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Observe the serial interface away from the active edge.
  always @(negedge CLK) begin
    if (!Reset) begin
      if (SCLK && !prev_sclk) q_sdo.push_back(SDO);
      if (rd_req) q_rd.push_back({rd_chip, rd_bit});
      if (LAT) begin
        q_lat.push_back(frame_done);
        lat_cyc = cyc;
        if (SCLK) lat_sclk_bad++;
      end
      if (frame_done) fd_cnt++;
      if (busy && wait_go) bw_bad++;
    end
    prev_sclk = SCLK;
  end

  // Frame store: data valid exactly one cycle after the strobe, garbage otherwise.
  initial begin
    logic [CW-1:0] rc;
    logic [9:0]    rb;
    logic [63:0]   t;
    rd_data = '0;
    forever begin
      @(negedge CLK);
      if (rd_req && !Reset) begin
        rc = rd_chip;
        rb = rd_bit;
        @(posedge CLK);
        #1 rd_data = mem[rc][rb];
        @(posedge CLK);
        t = {$urandom(), $urandom()};
        #1 rd_data = t[NL-1:0];
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [767:0] ctrl_vec(input logic [20:0] dc, input logic [8:0] mc,
                                            input logic [20:0] bc, input logic [4:0] fc);
    logic [767:0] v;
    v = 768'h0;
    for (int k = 0; k < 16; k++) v = v | (768'(dc) << (21 * k));
    v = v | (768'(mc) << 336) | (768'(bc) << 345) | (768'(fc) << 366) | (768'(8'h96) << 760);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_n(input int n, input int budget);
    for (int i = 0; i < budget && q_sdo.size() < n; i++) tick(1);
  endtask

  task automatic pulse_go();
    frame_go = 1'b1;
    tick(1);
    frame_go = 1'b0;
  endtask

  task automatic pulse_reload();
    cfg_reload = 1'b1;
    tick(1);
    cfg_reload = 1'b0;
  endtask

  task automatic set_rand_cfg(output logic [767:0] v, output logic [4:0] f);
    cfg_dc = 21'($urandom());
    cfg_mc = 9'($urandom());
    cfg_bc = 21'($urandom());
    cfg_fc = 5'($urandom());
    v = ctrl_vec(cfg_dc, cfg_mc, cfg_bc, cfg_fc);
    f = cfg_fc;
  endtask

  task automatic wait_lat(input string tag, input int budget, input logic exp_fd);
    logic fd;
    for (int i = 0; i < budget && q_lat.size() == 0; i++) tick(1);
    chk({tag, "_lat_cnt"}, q_lat.size(), 1);
    if (q_lat.size() > 0) begin
      fd = q_lat.pop_front();
      chk({tag, "_frame_done"}, fd, exp_fd);
    end
  endtask

  // Compare one whole frame against the rules: per chip, select bit then bits 767..0.
  task automatic check_frame(input logic is_ctrl, input logic [767:0] vec, input logic [4:0] fc,
                             input string tag);
    int errs;
    int rd_errs;
    logic [NL-1:0] s;
    logic [NL-1:0] e;
    logic [8:0]    hdr;
    logic [4:0]    fcv;
    logic [CW+9:0] r;
    errs = 0;
    rd_errs = 0;
    chk({tag, "_sclk_rises"}, q_sdo.size(), NB);
    if (q_sdo.size() >= NB) begin
      for (int c = NC - 1; c >= 0; c--) begin
        hdr = '0;
        fcv = '0;
        for (int b = 768; b >= 0; b--) begin
          s = q_sdo.pop_front();
          if (b == 768)     e = is_ctrl ? {NL{1'b1}} : {NL{1'b0}};
          else if (is_ctrl) e = {NL{vec[b]}};
          else              e = mem[c][b];
          e = e & tb_mask;
          if (s !== e) errs++;
          if (b >= 760) hdr = {hdr[7:0], s[0]};
          if (b <= 370 && b >= 366) fcv = {fcv[3:0], s[0]};
        end
        if (is_ctrl) begin
          chk($sformatf("%s_hdr_c%0d", tag, c), hdr, 9'h196);
          chk($sformatf("%s_fc_c%0d", tag, c), fcv, fc);
        end
      end
    end
    chk({tag, "_sdo_errs"}, errs, 0);
    if (is_ctrl) begin
      chk({tag, "_rd_cnt"}, q_rd.size(), 0);
    end else begin
      chk({tag, "_rd_cnt"}, q_rd.size(), NC * 768);
      for (int c = NC - 1; c >= 0; c--) begin
        for (int b = 767; b >= 0; b--) begin
          if (q_rd.size() > 0) begin
            r = q_rd.pop_front();
            if (r !== {CW'(c), 10'(b)}) rd_errs++;
          end else begin
            rd_errs++;
          end
        end
      end
      chk({tag, "_rd_order_errs"}, rd_errs, 0);
    end
    q_rd.delete();
  endtask

  initial begin
    logic [767:0] v1;
    logic [767:0] v5;
    logic [767:0] v8;
    logic [4:0]   f5;
    logic [4:0]   f8;
    logic [63:0]  t;

    Reset      = 1'b1;
    cfg_reload = 1'b0;
    frame_go   = 1'b0;
    cfg_dc     = 21'h1FFFFF;
    cfg_bc     = 21'h1FFFFF;
    cfg_mc     = 9'h0;
    cfg_fc     = 5'b11011;
`ifdef LANE_MASK_EN
    tb_mask    = 48'h1;
`else
    tb_mask    = {NL{1'b1}};
`endif
    v1 = ctrl_vec(cfg_dc, cfg_mc, cfg_bc, cfg_fc);
    for (int c = 0; c < NC; c++) begin
      for (int b = 0; b < 768; b++) begin
        t = {$urandom(), $urandom()};
        mem[c][b] = t[NL-1:0];
      end
    end

    tick(3);
    chk("rst_sdo", SDO, 0);
    chk("rst_sclk", SCLK, 0);
    chk("rst_lat", LAT, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_chip", rd_chip, 0);
    chk("rst_rd_bit", rd_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wait_go", wait_go, 0);
    chk("rst_frame_done", frame_done, 0);
    Reset = 1'b0;
    rel_cyc = cyc;

    // Frame 1: control upload after reset.
    wait_n(NB, 8000);
    check_frame(1'b1, v1, 5'b11011, "f1");
    wait_lat("f1", 20, 1'b0);
    chk("f1_lat_delay_ge_6152", (lat_cyc - rel_cyc) >= 6152, 1);

    // Frame 2: grayscale with go held low, then a late go.
    wait_n(NB, 8000);
    check_frame(1'b0, v1, 5'd0, "f2");
    tick(60);
    chk("f2_no_lat", q_lat.size(), 0);
    chk("f2_wait_go", wait_go, 1);
    chk("f2_busy", busy, 0);
    pulse_go();
    wait_lat("f2", 10, 1'b1);

    // Frame 3: go pulsed mid-shift latches without a further go.
    wait_n(700, 8000);
    pulse_go();
    wait_n(NB, 8000);
    check_frame(1'b0, v1, 5'd0, "f3");
    wait_lat("f3", 12, 1'b1);

    // Frame 4: reload and go during a grayscale shift; grayscale latches first.
    wait_n(300, 8000);
    pulse_reload();
    wait_n(400, 8000);
    set_rand_cfg(v5, f5);
    wait_n(800, 8000);
    pulse_go();
    wait_n(NB, 8000);
    check_frame(1'b0, v5, 5'd0, "f4");
    wait_lat("f4", 12, 1'b1);

    // Frame 5: control re-upload; cfg changes and a go during it are ignored.
    wait_n(200, 8000);
    pulse_go();
    set_rand_cfg(v8, f8);
    wait_n(NB, 8000);
    check_frame(1'b1, v5, f5, "f5");
    wait_lat("f5", 20, 1'b0);

    // Frame 6: grayscale resumes; the go seen during control was discarded.
    wait_n(NB, 8000);
    check_frame(1'b0, v5, 5'd0, "f6");
    tick(30);
    chk("f6_no_lat", q_lat.size(), 0);
    chk("f6_wait_go", wait_go, 1);
    pulse_go();
    wait_lat("f6", 10, 1'b1);

    // Frame 7: reset at bit 400 of chip 1 aborts; frame 8 restarts with a control upload.
    wait_n(369, 8000);
    chk("f7_reached_bit400", q_sdo.size() >= 369, 1);
    Reset = 1'b1;
    #1;
    chk("f7_rst_sdo", SDO, 0);
    chk("f7_rst_sclk", SCLK, 0);
    chk("f7_rst_busy", busy, 0);
    chk("f7_rst_rd_req", rd_req, 0);
    chk("f7_rst_lat", LAT, 0);
    tick(3);
    q_sdo.delete();
    q_rd.delete();
    q_lat.delete();
    Reset = 1'b0;
    wait_n(NB, 8000);
    check_frame(1'b1, v8, f8, "f8");
    wait_lat("f8", 20, 1'b0);

    chk("frame_done_pulses", fd_cnt, 4);
    chk("lat_with_sclk_high", lat_sclk_bad, 0);
    chk("busy_and_wait_go", bw_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
